// File: rtl/fir_mc_pkg.sv
// Shared types and arithmetic helpers for the time-multiplexed multi-channel FIR.
// The bench can use round_reduce as a reference model of the output scaling.
package fir_mc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    OUT  = 2'd2
  } state_t;

  // Accumulator width that cannot overflow over a full tap sweep.
  function automatic int acc_width(input int dw, input int cw, input int taps);
    return dw + cw + $clog2(taps);
  endfunction

  // Round half up by 2^(cw-1), then optionally clamp to the signed dw-bit range.
  // The caller keeps the low dw bits, which gives wrap-around when sat is 0.
  function automatic longint round_reduce(input longint acc, input int dw,
                                          input int cw, input bit sat);
    longint r;
    longint hi;
    longint lo;
    r  = (acc + (longint'(1) <<< (cw - 2))) >>> (cw - 1);
    hi = (longint'(1) <<< (dw - 1)) - 1;
    lo = -(longint'(1) <<< (dw - 1));
    if (sat) begin
      if (r > hi)      r = hi;
      else if (r < lo) r = lo;
    end
    return r;
  endfunction

endpackage

// File: rtl/fir_mc_if.sv
// Valid/ready sample stream into and filtered stream out of fir_mc.
interface fir_mc_if #(
  parameter int DW  = 10,
  parameter int CHW = 2
);
  logic                  s_valid;
  logic                  s_ready;
  logic [CHW-1:0]        s_ch;
  logic signed [DW-1:0]  s_data;
  logic                  m_valid;
  logic                  m_ready;
  logic [CHW-1:0]        m_ch;
  logic signed [DW-1:0]  m_data;

  modport slave (
    input  s_valid, s_ch, s_data, m_ready,
    output s_ready, m_valid, m_ch, m_data
  );

  modport master (
    output s_valid, s_ch, s_data, m_ready,
    input  s_ready, m_valid, m_ch, m_data
  );
endinterface

// File: rtl/fir_mc_mac.sv
// Shared multiply-accumulate with clear/enable and output round/reduce.
// FIR_MC_SAT_EN selects saturation; otherwise the result wraps modulo 2^DW.
module fir_mc_mac
  import fir_mc_pkg::*;
#(
  parameter int DW   = 10,
  parameter int CW   = 10,
  parameter int TAPS = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 en,
  input  logic signed [CW-1:0] coef,
  input  logic signed [DW-1:0] samp,
  output logic signed [DW-1:0] result
);

  localparam int ACCW = acc_width(DW, CW, TAPS);
`ifdef FIR_MC_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic signed [DW+CW-1:0] prod;
  logic signed [ACCW-1:0]  acc_q;

  assign prod = coef * samp;

  // NOTE: clocked state is assigned with <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       acc_q <= '0;
    else if (clr)   acc_q <= '0;
    else if (en)    acc_q <= acc_q + ACCW'(prod);
  end

  // acc_q is frozen outside MAC, so the result holds steady while stalled in OUT.
  always_comb begin
    result = DW'(round_reduce(longint'(acc_q), DW, CW, SAT));
  end

endmodule

// File: rtl/fir_mc.sv
// Multi-channel FIR: FSM, per-channel sample histories and shared coefficient set.
// Output saturation is enabled by defining FIR_MC_SAT_EN (see fir_mc_mac).
module fir_mc
  import fir_mc_pkg::*;
#(
  parameter int DW   = 10,
  parameter int CW   = 10,
  parameter int TAPS = 8,
  parameter int CH   = 4,
  localparam int CHW = (CH > 1) ? $clog2(CH) : 1,
  localparam int KW  = $clog2(TAPS)
) (
  input  logic                 clk,
  input  logic                 rst,
  fir_mc_if.slave              bus,
  input  logic                 coef_we,
  input  logic [KW-1:0]        coef_addr,
  input  logic signed [CW-1:0] coef_data,
  output logic                 busy
);

  state_t               state_q, state_d;
  logic [KW-1:0]        k_q;
  logic [CHW-1:0]       ch_q;
  logic signed [DW-1:0] hist [CH][TAPS];
  logic signed [CW-1:0] coef [TAPS];

  logic accept, ch_ok, coef_wr, last_tap, mac_clr, mac_en;

  assign bus.s_ready = rst && (state_q == IDLE);
  assign accept      = bus.s_valid && bus.s_ready;
  assign ch_ok       = {1'b0, bus.s_ch} < (CHW + 1)'(CH);
  assign coef_wr     = coef_we && (state_q == IDLE) && !accept;
  assign last_tap    = (k_q == KW'(TAPS - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // NOTE: every output of this block gets a default first, so no latch is inferred.
  always_comb begin
    state_d = state_q;
    mac_clr = 1'b0;
    mac_en  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept && ch_ok) begin
          mac_clr = 1'b1;
          state_d = MAC;
        end
      end
      MAC: begin
        mac_en = 1'b1;
        if (last_tap) state_d = OUT;
      end
      OUT: begin
        if (bus.m_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: histories and coefficients are flop arrays with reset, because every
  // word must read 0 after reset; a RAM macro could not be cleared this way.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      k_q  <= '0;
      ch_q <= '0;
      for (int c = 0; c < CH; c++)
        for (int t = 0; t < TAPS; t++)
          hist[c][t] <= '0;
      for (int t = 0; t < TAPS; t++)
        coef[t] <= '0;
    end else begin
      if (accept && ch_ok) begin
        ch_q                <= bus.s_ch;
        k_q                 <= '0;
        hist[bus.s_ch][0]   <= bus.s_data;
        for (int t = 1; t < TAPS; t++)
          hist[bus.s_ch][t] <= hist[bus.s_ch][t-1];
      end else if (state_q == MAC) begin
        k_q <= k_q + 1'b1;
      end
      if (coef_wr)
        coef[coef_addr] <= coef_data;
    end
  end

  fir_mc_mac #(
    .DW   (DW),
    .CW   (CW),
    .TAPS (TAPS)
  ) u_mac (
    .clk    (clk),
    .rst    (rst),
    .clr    (mac_clr),
    .en     (mac_en),
    .coef   (coef[k_q]),
    .samp   (hist[ch_q][k_q]),
    .result (bus.m_data)
  );

  assign bus.m_valid = (state_q == OUT);
  assign bus.m_ch    = ch_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_fir_mc.sv
// Directed bench for fir_mc with DW=CW=10, TAPS=4, CH=2; expected values hand-computed.
// Define FIR_MC_SAT_EN for both bench and RTL to check the saturating build.
module tb_fir_mc;

  localparam int DW   = 10;
  localparam int CW   = 10;
  localparam int TAPS = 4;
  localparam int CH   = 2;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 coef_we;
  logic [1:0]           coef_addr;
  logic signed [CW-1:0] coef_data;
  logic                 busy;

  int checks = 0;
  int errors = 0;

  fir_mc_if #(.DW(DW), .CHW(1)) bus ();

  fir_mc #(.DW(DW), .CW(CW), .TAPS(TAPS), .CH(CH)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .coef_we   (coef_we),
    .coef_addr (coef_addr),
    .coef_data (coef_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic               ch;
    logic signed [9:0]  din;
    logic signed [9:0]  exp;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic write_coef(input logic [1:0] addr, input logic signed [9:0] data);
    @(negedge clk);
    coef_we   = 1'b1;
    coef_addr = addr;
    coef_data = data;
    @(posedge clk);
    #1 coef_we = 1'b0;
  endtask

  task automatic push(input logic ch, input logic signed [9:0] d);
    int n = 0;
    @(negedge clk);
    while (!bus.s_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("s_ready before push", bus.s_ready, 1);
    bus.s_valid = 1'b1;
    bus.s_ch    = ch;
    bus.s_data  = d;
    @(posedge clk);
    #1 bus.s_valid = 1'b0;
  endtask

  // Negedges counted from the accept edge until m_valid is seen.
  task automatic wait_out(output int lat);
    int n = 0;
    @(negedge clk);
    while (!bus.m_valid && n < 30) begin
      n++;
      @(negedge clk);
    end
    check("m_valid arrives", bus.m_valid, 1);
    lat = n;
  endtask

  task automatic pop();
    bus.m_ready = 1'b1;
    @(posedge clk);
    #1 bus.m_ready = 1'b0;
  endtask

  initial begin
    int lat;
    logic signed [9:0] held;
    logic signed [9:0] sat_exp;

    vecs[0] = '{1'b0, 10'sd511, 10'sd256};   // impulse through ch0
    vecs[1] = '{1'b0, 10'sd0,   10'sd128};
    vecs[2] = '{1'b0, 10'sd0,  -10'sd255};
    vecs[3] = '{1'b0, 10'sd0,   10'sd64};
    vecs[4] = '{1'b0, 10'sd511, 10'sd256};   // isolation: 511 pushes old impulse out
    vecs[5] = '{1'b1, 10'sd0,   10'sd0};
    vecs[6] = '{1'b1, 10'sd0,   10'sd0};
    vecs[7] = '{1'b1, 10'sd0,   10'sd0};
    vecs[8] = '{1'b0, 10'sd0,   10'sd128};

    rst         = 1'b0;
    bus.s_valid = 1'b0;
    bus.s_ch    = 1'b0;
    bus.s_data  = '0;
    bus.m_ready = 1'b0;
    coef_we     = 1'b0;
    coef_addr   = '0;
    coef_data   = '0;

    #2;
    check("reset s_ready", bus.s_ready, 0);
    check("reset m_valid", bus.m_valid, 0);
    check("reset m_data",  bus.m_data, 0);
    check("reset m_ch",    bus.m_ch, 0);
    check("reset busy",    busy, 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1 check("s_ready after reset", bus.s_ready, 1);

    write_coef(2'd0,  10'sd256);
    write_coef(2'd1,  10'sd128);
    write_coef(2'd2, -10'sd256);
    write_coef(2'd3,  10'sd64);

    for (int i = 0; i < 9; i++) begin
      push(vecs[i].ch, vecs[i].din);
      wait_out(lat);
      check($sformatf("vec%0d m_data", i), bus.m_data, vecs[i].exp);
      check($sformatf("vec%0d m_ch", i), bus.m_ch, vecs[i].ch);
      check($sformatf("vec%0d latency", i), lat, TAPS);
      pop();
    end

    // Backpressure: ch0 history is now {0,511,0,0}; next 0 gives -256*511 -> -255.
    push(1'b0, 10'sd0);
    wait_out(lat);
    held = bus.m_data;
    check("bp m_data", held, -255);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check($sformatf("bp stable c%0d", c), bus.m_data, -255);
      check($sformatf("bp s_ready c%0d", c), bus.s_ready, 0);
      check($sformatf("bp m_valid c%0d", c), bus.m_valid, 1);
    end
    pop();
    @(negedge clk);
    check("bp s_ready after release", bus.s_ready, 1);
    check("bp m_valid after release", bus.m_valid, 0);

    // Coefficient write during MAC must be ignored.
    push(1'b1, 10'sd511);
    @(negedge clk);
    @(negedge clk);
    check("busy during MAC", busy, 1);
    coef_we   = 1'b1;
    coef_addr = 2'd0;
    coef_data = 10'sd0;
    @(posedge clk);
    #1 coef_we = 1'b0;
    wait_out(lat);
    check("busy-write impulse", bus.m_data, 256);
    pop();
    // ch1 history {511,511,0,0}: (256+128)*511 -> 383; 128 if coef[0] were cleared.
    push(1'b1, 10'sd511);
    wait_out(lat);
    check("coef0 kept", bus.m_data, 383);
    check("coef0 kept m_ch", bus.m_ch, 1);
    pop();

    // Saturation: all taps 511, four 511 samples -> 2040 before reduction.
    for (int t = 0; t < 4; t++) write_coef(2'(t), 10'sd511);
    for (int s = 0; s < 4; s++) begin
      push(1'b0, 10'sd511);
      wait_out(lat);
      if (s == 3) begin
`ifdef FIR_MC_SAT_EN
        sat_exp = 10'sd511;
`else
        sat_exp = -10'sd8;
`endif
        check("saturation out", bus.m_data, sat_exp);
      end
      pop();
    end

    // Reset two cycles into MAC.
    push(1'b0, 10'sd100);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("mid-MAC reset m_valid", bus.m_valid, 0);
    check("mid-MAC reset busy",    busy, 0);
    check("mid-MAC reset s_ready", bus.s_ready, 0);
    check("mid-MAC reset m_data",  bus.m_data, 0);
    @(negedge clk);
    rst = 1'b1;
    #1 check("post-reset s_ready", bus.s_ready, 1);
    push(1'b0, 10'sd511);
    wait_out(lat);
    check("post-reset zero coef out", bus.m_data, 0);
    check("post-reset latency", lat, TAPS);
    pop();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fir_mc.md
# fir_mc

Time-multiplexed, multi-channel FIR filter with runtime-loadable coefficients and valid/ready streaming on both sides. It succeeds the fixed-coefficient single-channel FIR. One shared multiply-accumulate unit serves CH independent channels, each with its own TAPS-deep sample history. It sits between a channelised sample source and any downstream consumer that can apply backpressure.

## Interface
- DW, 10: sample width, signed Q1.(DW-1), used for input and output.
- CW, 10: coefficient width, signed Q1.(CW-1).
- TAPS, 8: filter length, must be ≥2.
- CH, 4: number of channels, must be ≥1. CHW = max(1, $clog2(CH)).
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active-low.
- s_valid  in  1  input sample valid.
- s_ready  out  1  block can accept a sample.
- s_ch  in  CHW  channel index of the input sample; values ≥CH are dropped after the handshake.
- s_data  in  DW  input sample.
- m_valid  out  1  output sample valid.
- m_ready  in  1  consumer accepts the output.
- m_ch  out  CHW  channel of the output sample.
- m_data  out  DW  filtered sample.
- coef_we  in  1  coefficient write strobe.
- coef_addr  in  $clog2(TAPS)  tap index.
- coef_data  in  CW  coefficient value; the set is shared by all channels.
- busy  out  1  high whenever the state is not IDLE.

## Operation
- State machine with three states: IDLE, MAC, OUT.
- IDLE: s_ready=1. When s_valid && s_ready, do all of the following in the same edge:
  - Shift the history of channel s_ch: hist[ch][0]←s_data, hist[ch][i]←hist[ch][i-1].
  - Latch the channel index.
  - Clear the accumulator and the tap counter.
  - Go to MAC.
- s_ch ≥ CH: the sample is accepted, no history changes, no output is produced, and the state stays in IDLE.
- MAC: each cycle, acc += coef[k]·hist[ch][k] for k = 0..TAPS-1. On k = TAPS-1, go to OUT.
- OUT: m_valid=1, and m_data/m_ch are held stable. On m_ready, go to IDLE.
- Result: y = Σ coef[i]·x[n-i], computed over the selected channel only.
- Arithmetic:
  - Product width is DW+CW. Accumulator width is ACCW = DW+CW+$clog2(TAPS), so no overflow is possible.
  - Final scaling: (acc + 2^(CW-2)) >>> (CW-1), i.e. round half up, then reduce to DW bits (see Configuration).
- Coefficient writes:
  - Applied only while in IDLE and while no input handshake is occurring in the same cycle.
  - Writes at any other time are ignored, and busy indicates this.
- Reset values:
  - s_ready=0 while rst is low, then 1 in IDLE.
  - m_valid=0, m_data=0, m_ch=0, busy=0.
  - All coefficients and all history registers are 0.
- Reset asserted mid-MAC or mid-OUT aborts immediately. The pending result is lost, and all state is cleared asynchronously.

## Timing
- Input handshake on edge E0. MAC occupies edges E1..E_TAPS. m_valid rises after edge E_TAPS and is visible from the following cycle.
- Output handshake on edge Eo. IDLE is reached on Eo, so s_ready=1 in the next cycle.
- Minimum sample period is TAPS+2 cycles.
- Stalls: m_data must not change while m_valid && !m_ready. No input is accepted while outside IDLE.
- Coefficient write in IDLE on edge Ew: the new value is used by any MAC starting on or after Ew+1.

## Configuration
- FIR_MC_SAT_EN defined: the scaled result is saturated to [-2^(DW-1), 2^(DW-1)-1].
- FIR_MC_SAT_EN undefined: the low DW bits are taken and overflow wraps modulo 2^DW. No saturation logic is synthesised.

## Structure
- Package fir_mc_pkg contains:
  - the state enum typedef (IDLE, MAC, OUT);
  - a function returning ACCW from DW, CW and TAPS;
  - a round/reduce function used by both the RTL and the bench model.
- Sub-module fir_mc_mac holds the multiplier, the accumulator with its clear/enable controls, and round/saturate. The top level holds the FSM, the history RAM-style arrays and the coefficient registers.

## Test plan
All scenarios use DW=CW=10, TAPS=4, CH=2 unless noted.
- Impulse on ch0:
  - Stimulus: coef = {256, 128, -256, 64}; feed ch0 samples 511, 0, 0, 0.
  - Required: m_data = 256, 128, -255, 64, all with m_ch=0.
- Channel isolation:
  - Stimulus: same coefficients; feed ch0=511, then ch1=0 three times, then ch0=0.
  - Required: ch1 outputs are all 0, and the second ch0 output is 128.
- Backpressure:
  - Stimulus: hold m_ready=0 for 10 cycles after m_valid rises.
  - Required: m_data stable, s_ready=0 throughout; after m_ready=1 for one cycle, s_ready=1 on the next cycle.
- Saturation:
  - Stimulus: all coefficients 511; feed ch0 = 511 four times.
  - Required: fourth output is 511 with FIR_MC_SAT_EN, and -8 without it.
- Coefficient write while busy:
  - Stimulus: write coef[0]=0 during MAC.
  - Required: busy=1, the write is ignored, and the next impulse still yields 256 on tap 0.
- Reset mid-MAC:
  - Stimulus: drop rst two cycles into MAC.
  - Required: m_valid=0 immediately. After release, s_ready=1, and all outputs are 0 until new coefficients are loaded.
